// File: rtl/zero_program_runner.sv
// Runs a loaded zero-style program, streams out-channel words and checks them against a loaded expected table.
// Latency: one instruction per cycle after an NLocal-cycle clear; out word and finished appear one cycle after the deciding instruction.
// Backpressure: an out/outl instruction parks the machine in OUTWAIT until out_valid && out_ready.
module zero_program_runner #(
    parameter int MemoryElementWidth = 12,
    parameter int NInstructions      = 64,
    parameter int NLocal             = 64,
    parameter int NExpect            = 32,
    parameter int MaxSteps           = 1000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              load_valid,
    input  logic                              load_sel,
    input  logic [15:0]                       load_addr,
    input  logic [4+2*MemoryElementWidth-1:0] load_data,
    input  logic [15:0]                       expect_count,
    input  logic                              run,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MemoryElementWidth-1:0]     out_data,
    output logic                              busy,
    output logic                              finished,
    output logic                              success,
    output logic [31:0]                       steps
);
    localparam int W   = MemoryElementWidth;
    localparam int IW  = 4 + 2 * W;
    localparam int IAW = $clog2(NInstructions);
    localparam int LAW = $clog2(NLocal);
    localparam int EAW = $clog2(NExpect);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_OUTWAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [IAW-1:0] IP_LAST   = IAW'(NInstructions - 1);
    localparam logic [LAW-1:0] CLR_LAST  = LAW'(NLocal - 1);
    localparam logic [31:0]    STEP_MAX  = 32'(MaxSteps);
    localparam logic [15:0]    EXP_DEPTH = 16'(NExpect);

    logic [IW-1:0] imem [NInstructions];
    logic [W-1:0]  emem [NExpect];
    logic [W-1:0]  lmem [NLocal];

    logic [2:0]     state_q, state_d;
    logic [IAW-1:0] ip_q, ip_d;
    logic [31:0]    steps_q, steps_d;
    logic [15:0]    out_count_q, out_count_d;
    logic [15:0]    expect_cnt_q, expect_cnt_d;
    logic [LAW-1:0] clr_q, clr_d;
    logic           mismatch_q, mismatch_d;
    logic           success_q, success_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;

    logic           load_ok, im_we, em_we;
    logic           lm_we;
    logic [LAW-1:0] lm_waddr;
    logic [W-1:0]   lm_wdata;
    logic [IW-1:0]  instr;
    logic [3:0]     op;
    logic [W-1:0]   fa, fb, loc_a, loc_b, exp_word, out_word;
    logic           adv, end_ok, end_bad, issue, good;
    logic           unused_bits;

    assign instr    = imem[ip_q];
    assign op       = instr[IW-1 -: 4];
    assign fa       = instr[2*W-1 -: W];
    assign fb       = instr[W-1:0];
    assign loc_a    = lmem[fa[LAW-1:0]];
    assign loc_b    = lmem[fb[LAW-1:0]];
    assign exp_word = emem[out_count_q[EAW-1:0]];
    assign good     = !mismatch_q && (out_count_q == expect_cnt_q);

    // Loader may only touch the memories while no program is running.
    assign load_ok = (state_q == S_IDLE) || (state_q == S_DONE);
    assign im_we   = load_ok && load_valid && !load_sel;
    assign em_we   = load_ok && load_valid && load_sel;

    assign unused_bits = ^{load_addr, load_data, fa, fb};

    // Next-state logic: run start, local clear, instruction execute and out handshake.
    always_comb begin
        state_d      = state_q;
        ip_d         = ip_q;
        steps_d      = steps_q;
        out_count_d  = out_count_q;
        expect_cnt_d = expect_cnt_q;
        clr_d        = clr_q;
        mismatch_d   = mismatch_q;
        success_d    = success_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        lm_we        = 1'b0;
        lm_waddr     = clr_q;
        lm_wdata     = '0;
        adv          = 1'b0;
        end_ok       = 1'b0;
        end_bad      = 1'b0;
        issue        = 1'b0;
        out_word     = fb;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (run) begin
                    state_d      = S_CLEAR;
                    clr_d        = '0;
                    ip_d         = '0;
                    steps_d      = '0;
                    out_count_d  = '0;
                    mismatch_d   = 1'b0;
                    success_d    = 1'b0;
                    expect_cnt_d = expect_count;
                end
            end
            S_CLEAR: begin
                lm_we    = 1'b1;
                lm_waddr = clr_q;
                clr_d    = clr_q + LAW'(1);
                if (clr_q == CLR_LAST) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                steps_d = steps_q + 32'd1;
                case (op)
                    4'd0: adv = 1'b1;
                    4'd1: ip_d = fa[IAW-1:0];
                    4'd2: begin
                        if (loc_b == '0) ip_d = fa[IAW-1:0];
                        else             adv  = 1'b1;
                    end
                    4'd3: begin
                        lm_we    = 1'b1;
                        lm_waddr = fa[LAW-1:0];
                        lm_wdata = fb;
                        adv      = 1'b1;
                    end
                    4'd4: begin
                        lm_we    = 1'b1;
                        lm_waddr = fa[LAW-1:0];
                        lm_wdata = loc_a + fb;
                        adv      = 1'b1;
                    end
                    4'd5: begin
                        issue    = 1'b1;
                        out_word = fb;
                    end
                    4'd6: begin
                        issue    = 1'b1;
                        out_word = loc_b;
                    end
                    4'd7:    end_ok  = 1'b1;
                    default: end_bad = 1'b1;
                endcase
                // Stepping past the last instruction ends the run; there is no wrap.
                if (adv) begin
                    ip_d = ip_q + IAW'(1);
                    if (ip_q == IP_LAST) end_ok = 1'b1;
                end
                if (end_ok) begin
                    state_d   = S_DONE;
                    success_d = good;
                end else if (end_bad || (steps_d == STEP_MAX)) begin
                    state_d   = S_DONE;
                    success_d = 1'b0;
                end else if (issue) begin
                    state_d     = S_OUTWAIT;
                    out_valid_d = 1'b1;
                    out_data_d  = out_word;
                    if ((out_count_q >= EXP_DEPTH) || (out_word != exp_word)) begin
                        mismatch_d = 1'b1;
                    end
                    if (out_count_q != 16'hFFFF) begin
                        out_count_d = out_count_q + 16'd1;
                    end
                end
            end
            S_OUTWAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (ip_q == IP_LAST) begin
                        state_d   = S_DONE;
                        success_d = good;
                    end else begin
                        ip_d    = ip_q + IAW'(1);
                        state_d = S_EXEC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset returns everything to idle immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ip_q         <= '0;
            steps_q      <= '0;
            out_count_q  <= '0;
            expect_cnt_q <= '0;
            clr_q        <= '0;
            mismatch_q   <= 1'b0;
            success_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            ip_q         <= ip_d;
            steps_q      <= steps_d;
            out_count_q  <= out_count_d;
            expect_cnt_q <= expect_cnt_d;
            clr_q        <= clr_d;
            mismatch_q   <= mismatch_d;
            success_q    <= success_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    // Loaded memories survive runs but are wiped by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NInstructions; i++) imem[i] <= '0;
            for (int i = 0; i < NExpect; i++)       emem[i] <= '0;
        end else begin
            if (im_we) imem[load_addr[IAW-1:0]] <= load_data;
            if (em_we) emem[load_addr[EAW-1:0]] <= load_data[W-1:0];
        end
    end

    // Local scratch memory; cleared by the CLEAR phase rather than by reset.
    always_ff @(posedge clock) begin
        if (lm_we) lmem[lm_waddr] <= lm_wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == S_CLEAR) || (state_q == S_EXEC) || (state_q == S_OUTWAIT);
    assign finished  = (state_q == S_DONE);
    assign success   = success_q;
    assign steps     = steps_q;
endmodule

// File: tb/tb_zero_program_runner.sv
// Scoreboarded directed bench for zero_program_runner.
// Expected out words are queued before each run; a negedge monitor pops and compares on every accepted word.
// out_ready is shaped by ready_mode: 0 always high, 1 five-cycle stall per word, 2 held low.
module tb_zero_program_runner;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_sel = 1'b0;
    logic [15:0] load_addr = '0;
    logic [27:0] load_data = '0;
    logic [15:0] expect_count = '0;
    logic        run = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] out_data;
    logic        busy, finished, success;
    logic [31:0] steps;

    int          n_vec = 0;
    int          n_fail = 0;
    int          ready_mode = 0;
    int          stall_cnt = 0;
    logic [11:0] sb[$];
    logic [27:0] prog[64];

    zero_program_runner dut (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .expect_count(expect_count), .run(run),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .finished(finished), .success(success), .steps(steps)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Consumer side: shape out_ready according to ready_mode.
    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 2) out_ready = 1'b0;
        else if (!out_valid) begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end else if (stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
        end else out_ready = 1'b1;
    end

    // Monitor: pop on accepted words, check the presented word against the queue head while stalled.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_out: got %0d, required no output", out_data);
            end else if (out_ready) begin
                check("out_word", {20'd0, out_data}, {20'd0, sb.pop_front()});
            end else begin
                check("out_held", {20'd0, out_data}, {20'd0, sb[0]});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [27:0] ins(input int op, input int a, input int b);
        return {4'(op), 12'(a), 12'(b)};
    endfunction

    task automatic load_word(input logic sel, input int addr, input logic [27:0] data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_addr  = 16'(addr);
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fill_prog(input int op);
        for (int i = 0; i < 64; i++) prog[i] = ins(op, 0, 0);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) load_word(1'b0, i, prog[i]);
    endtask

    task automatic run_wait(input int cnt, input string name);
        expect_count = 16'(cnt);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) tick();
        if (!finished) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got finished=0, required finished=1", name);
        end
        tick();
    endtask

    task automatic prog_a();
        fill_prog(7);
        prog[0] = ins(1, 3, 0);
        prog[1] = ins(5, 0, 1);
        prog[2] = ins(1, 5, 0);
        prog[3] = ins(0, 0, 0);
        prog[4] = ins(5, 0, 2);
        prog[5] = ins(0, 0, 0);
        load_prog();
    endtask

    task automatic prog_loop();
        fill_prog(7);
        prog[0] = ins(3, 0, 3);
        prog[1] = ins(0, 0, 0);
        prog[2] = ins(6, 0, 0);
        prog[3] = ins(4, 0, 4095);
        prog[4] = ins(2, 6, 0);
        prog[5] = ins(1, 1, 0);
        prog[6] = ins(7, 0, 0);
        load_prog();
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_finished", {31'd0, finished}, 32'd0);
        check("rst_success", {31'd0, success}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {20'd0, out_data}, 32'd0);
        check("rst_steps", steps, 32'd0);
        reset = 1'b0;
        tick();

        // Jump-over program with matching expectation.
        prog_a();
        load_word(1'b1, 0, 28'd2);
        sb.push_back(12'd2);
        run_wait(1, "a");
        check("a_finished", {31'd0, finished}, 32'd1);
        check("a_success", {31'd0, success}, 32'd1);
        check("a_steps", steps, 32'd5);
        check("a_drained", sb.size(), 32'd0);

        // Same program, wrong expected word.
        load_word(1'b1, 0, 28'd1);
        sb.push_back(12'd2);
        run_wait(1, "b");
        check("b_success", {31'd0, success}, 32'd0);
        check("b_steps", steps, 32'd5);
        check("b_drained", sb.size(), 32'd0);

        // Countdown loop, free-flowing then stalled consumer.
        prog_loop();
        load_word(1'b1, 0, 28'd3);
        load_word(1'b1, 1, 28'd2);
        load_word(1'b1, 2, 28'd1);
        for (int pass = 0; pass < 2; pass++) begin
            ready_mode = pass;
            sb.push_back(12'd3);
            sb.push_back(12'd2);
            sb.push_back(12'd1);
            run_wait(3, "loop");
            check("loop_success", {31'd0, success}, 32'd1);
            check("loop_steps", steps, 32'd16);
            check("loop_drained", sb.size(), 32'd0);
        end
        ready_mode = 0;

        // Endless jump hits the step limit.
        fill_prog(1);
        load_prog();
        run_wait(0, "limit");
        check("limit_steps", steps, 32'd1000);
        check("limit_success", {31'd0, success}, 32'd0);

        // Illegal opcode at ip 2 aborts even though the out count matches.
        fill_prog(0);
        prog[2] = ins(9, 0, 0);
        load_prog();
        run_wait(0, "illegal");
        check("illegal_steps", steps, 32'd3);
        check("illegal_success", {31'd0, success}, 32'd0);

        // All nops: falls off the end of instruction memory successfully.
        fill_prog(0);
        load_prog();
        run_wait(0, "falloff");
        check("falloff_steps", steps, 32'd64);
        check("falloff_success", {31'd0, success}, 32'd1);

        // Reset while parked in OUTWAIT.
        prog_loop();
        ready_mode = 2;
        sb.push_back(12'd3);
        expect_count = 16'd3;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 200 && !out_valid; i++) tick();
        check("ow_reached", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("ow_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("ow_rst_finished", {31'd0, finished}, 32'd0);
        check("ow_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        sb.delete();
        ready_mode = 0;
        reset = 1'b0;
        tick();
        prog_a();
        load_word(1'b1, 0, 28'd2);
        sb.push_back(12'd2);
        run_wait(1, "post_rst");
        check("post_rst_success", {31'd0, success}, 32'd1);
        check("post_rst_steps", steps, 32'd5);
        check("post_rst_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
